// File: rtl/snoop_dispatch.sv
// snoop_dispatch
// Round-robin dispatcher between the packet snooper and N packetfilter cores.
// The snooper sees a single rdy_for_sn / rdy_for_sn_ack handshake; behind it
// one ready core is chosen per packet and owns the write and done strobes
// until the packet's done pulse. Writes that arrive while no core owns the
// bus are dropped and counted in a saturating counter.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   sn_addr/sn_wr_data/...    snooper write side (addr, data, wr_en, byte_inc, done)
//   rdy_for_sn, rdy_for_sn_ack  logical offer / accept handshake to the snooper
//   core_rdy_for_sn           per-core ready inputs
//   core_rdy_for_sn_ack       per-core accept pulse (one-hot or zero)
//   core_sn_addr/wr_data/byte_inc  broadcast copies of the snooper buses
//   core_sn_wr_en/core_sn_done     gated strobes (one-hot or zero)
//   core_sel                  index of the currently selected core
//   drop_cnt                  saturating count of writes with no owner
module snoop_dispatch #(
    parameter int N_CORES            = 4,
    parameter int PACKMEM_ADDR_WIDTH = 8,
    parameter int PACKMEM_DATA_WIDTH = 64,
    parameter int INC_WIDTH          = 4,
    parameter int SEL_WIDTH          = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PACKMEM_ADDR_WIDTH-1:0] sn_addr,
    input  logic [PACKMEM_DATA_WIDTH-1:0] sn_wr_data,
    input  logic                          sn_wr_en,
    input  logic [INC_WIDTH-1:0]          sn_byte_inc,
    input  logic                          sn_done,
    output logic                          rdy_for_sn,
    input  logic                          rdy_for_sn_ack,
    input  logic [N_CORES-1:0]            core_rdy_for_sn,
    output logic [N_CORES-1:0]            core_rdy_for_sn_ack,
    output logic [PACKMEM_ADDR_WIDTH-1:0] core_sn_addr,
    output logic [PACKMEM_DATA_WIDTH-1:0] core_sn_wr_data,
    output logic [INC_WIDTH-1:0]          core_sn_byte_inc,
    output logic [N_CORES-1:0]            core_sn_wr_en,
    output logic [N_CORES-1:0]            core_sn_done,
    output logic [SEL_WIDTH-1:0]          core_sel,
    output logic [15:0]                   drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [SEL_WIDTH-1:0]   rr_ptr_r, rr_ptr_s;
    logic [SEL_WIDTH-1:0]   core_sel_r, core_sel_s;
    logic [SEL_WIDTH-1:0]   hi_pick_s, lo_pick_s, pick_s, rr_after_s;
    logic                   hi_found_s;
    logic [N_CORES-1:0]     sel_oh_s;
    logic                   sel_rdy_s;
    logic [15:0]            drop_cnt_r;

    // Round-robin search: lowest ready index at or above rr_ptr, else lowest ready
    // index overall (the wrap-around part). Descending loops leave the lowest match.
    always_comb begin
        hi_pick_s  = {SEL_WIDTH{1'b0}};
        lo_pick_s  = {SEL_WIDTH{1'b0}};
        hi_found_s = 1'b0;
        for (int j = N_CORES - 1; j >= 0; j--) begin
            if (core_rdy_for_sn[j] && (j >= int'(rr_ptr_r))) begin
                hi_pick_s  = SEL_WIDTH'(j);
                hi_found_s = 1'b1;
            end else begin
                hi_found_s = hi_found_s;
            end
            if (core_rdy_for_sn[j]) begin
                lo_pick_s = SEL_WIDTH'(j);
            end else begin
                lo_pick_s = lo_pick_s;
            end
        end
        if (hi_found_s) begin
            pick_s = hi_pick_s;
        end else begin
            pick_s = lo_pick_s;
        end
    end

    // One-hot decode of the selected core; also used to read its ready bit
    // without a variable-width index.
    always_comb begin
        sel_oh_s = {N_CORES{1'b0}};
        for (int j = 0; j < N_CORES; j++) begin
            sel_oh_s[j] = (core_sel_r == SEL_WIDTH'(j));
        end
        sel_rdy_s = |(core_rdy_for_sn & sel_oh_s);
    end

    // Pointer value after the current packet; wraps at N_CORES-1 so unused
    // indices of a non-power-of-two core count are never visited.
    always_comb begin
        if (core_sel_r == SEL_WIDTH'(N_CORES - 1)) begin
            rr_after_s = {SEL_WIDTH{1'b0}};
        end else begin
            rr_after_s = core_sel_r + SEL_WIDTH'(1);
        end
    end

    // Next-state logic and the combinational ack / gating outputs.
    always_comb begin
        state_s             = state_r;
        rr_ptr_s            = rr_ptr_r;
        core_sel_s          = core_sel_r;
        rdy_for_sn          = 1'b0;
        core_rdy_for_sn_ack = {N_CORES{1'b0}};
        core_sn_wr_en       = {N_CORES{1'b0}};
        core_sn_done        = {N_CORES{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (|core_rdy_for_sn) begin
                    core_sel_s = pick_s;
                    state_s    = ST_OFFER;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_OFFER: begin
                rdy_for_sn = sel_rdy_s;
                if (!sel_rdy_s) begin
                    // Offer withdrawn by the core: reselect from IDLE.
                    state_s = ST_IDLE;
                end else if (rdy_for_sn_ack) begin
                    core_rdy_for_sn_ack = sel_oh_s;
                    state_s             = ST_BUSY;
                end else begin
                    state_s = ST_OFFER;
                end
            end
            ST_BUSY: begin
                core_sn_wr_en = sn_wr_en ? sel_oh_s : {N_CORES{1'b0}};
                core_sn_done  = sn_done  ? sel_oh_s : {N_CORES{1'b0}};
                if (sn_done) begin
                    state_s  = ST_IDLE;
                    rr_ptr_s = rr_after_s;
                end else begin
                    state_s  = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, round-robin pointer and selected core registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= {SEL_WIDTH{1'b0}};
            core_sel_r <= {SEL_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            core_sel_r <= core_sel_s;
        end
    end

    // Saturating count of writes seen while no core owns the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (sn_wr_en && (state_r != ST_BUSY) && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign core_sn_addr     = sn_addr;
    assign core_sn_wr_data  = sn_wr_data;
    assign core_sn_byte_inc = sn_byte_inc;
    assign core_sel         = core_sel_r;
    assign drop_cnt         = drop_cnt_r;

endmodule
